// File: rtl/signed_divider16.sv
// Sequential signed divider: restoring division on magnitudes, one quotient bit per cycle, sign fix-up at the end.
// Define DIV_ZERO_FAST_EN to skip the iterations for a zero divisor (results are identical either way).
module signed_divider16 #(
    parameter int WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] dividend,
    input  logic signed [WIDTH-1:0] divisor,
    output logic signed [WIDTH-1:0] quotient,
    output logic signed [WIDTH-1:0] remainder,
    output logic                    div_by_zero,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

    state_t                  state_q;
    logic [4:0]              cnt_q;
    logic                    sign_n_q;
    logic                    sign_d_q;
    logic                    zero_q;
    logic signed [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0]        dq_q;
    logic [WIDTH-1:0]        dvs_q;
    // The remainder after a step is always below |divisor| <= 2^(WIDTH-1), so
    // only the shifted trial value needs the extra bit.
    logic [WIDTH-1:0]        rem_q;

    logic [WIDTH:0]          rem_shift_d;
    logic [WIDTH:0]          rem_sub_d;
    logic                    q_bit_d;

    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
        logic [WIDTH-1:0] u;
        u = v;
        return v[WIDTH-1] ? (~u + 1'b1) : u;
    endfunction

    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    assign rem_shift_d = {rem_q, dq_q[WIDTH-1]};
    assign q_bit_d     = (rem_shift_d >= {1'b0, dvs_q});
    assign rem_sub_d   = rem_shift_d - {1'b0, dvs_q};

    // Control, flags and result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        busy  <= 1'b1;
                        cnt_q <= '0;
`ifdef DIV_ZERO_FAST_EN
                        state_q <= (divisor == '0) ? FIX : ITER;
`else
                        state_q <= ITER;
`endif
                    end
                end
                ITER: begin
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'(WIDTH - 1)) state_q <= FIX;
                end
                FIX: begin
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state_q     <= IDLE;
                    div_by_zero <= zero_q;
                    quotient    <= zero_q ? '1 : neg_if(dq_q, sign_n_q ^ sign_d_q);
                    remainder   <= zero_q ? dvd_q : neg_if(rem_q, sign_n_q);
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Datapath: operand capture, then shift/subtract per iteration
    always_ff @(posedge clk) begin
        if (state_q == IDLE && start) begin
            sign_n_q <= dividend[WIDTH-1];
            sign_d_q <= divisor[WIDTH-1];
            zero_q   <= (divisor == '0);
            dvd_q    <= dividend;
            dq_q     <= magnitude(dividend);
            dvs_q    <= magnitude(divisor);
            rem_q    <= '0;
        end else if (state_q == ITER) begin
            rem_q <= q_bit_d ? rem_sub_d[WIDTH-1:0] : rem_shift_d[WIDTH-1:0];
            dq_q  <= {dq_q[WIDTH-2:0], q_bit_d};
        end
    end

endmodule

// File: tb/tb_signed_divider16.sv
// Directed self-checking bench for signed_divider16; honours DIV_ZERO_FAST_EN for the zero-divisor latency.
module tb_signed_divider16;

    logic               clk;
    logic               reset;
    logic               start;
    logic signed [15:0] dividend;
    logic signed [15:0] divisor;
    logic signed [15:0] quotient;
    logic signed [15:0] remainder;
    logic               div_by_zero;
    logic               busy;
    logic               done;

    int total = 0;
    int bad   = 0;

`ifdef DIV_ZERO_FAST_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 17;
`endif

    signed_divider16 #(.WIDTH(16)) dut (
        .clk(clk), .reset(reset), .start(start),
        .dividend(dividend), .divisor(divisor),
        .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one operation and return edges from the accepting edge to done (-1 on timeout)
    task automatic run_op(input logic signed [15:0] a, input logic signed [15:0] b,
                          output int lat, output int busy_cnt);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        busy_cnt = int'(busy);
        lat      = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
            busy_cnt += int'(busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (quotient !== 16'h0000) begin bad++; $display("FAIL reset_q got=%h want=0000", quotient); end
        total++; if (remainder !== 16'h0000) begin bad++; $display("FAIL reset_r got=%h want=0000", remainder); end
        total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dbz got=%b want=0", div_by_zero); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_positive();
        int lat, bc;
        run_op(16'sd100, 16'sd7, lat, bc);
        total++; if (lat != 17) begin bad++; $display("FAIL pos_latency got=%0d want=17", lat); end
        total++; if (quotient !== 16'd14) begin bad++; $display("FAIL pos_q got=%h want=000e", quotient); end
        total++; if (remainder !== 16'd2) begin bad++; $display("FAIL pos_r got=%h want=0002", remainder); end
        total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL pos_dbz got=%b want=0", div_by_zero); end
        total++; if (bc != 17) begin bad++; $display("FAIL pos_busy_cycles got=%0d want=17", bc); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL pos_busy_at_done got=%b want=0", busy); end
        @(posedge clk);
        #1;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL pos_done_one_cycle got=%b want=0", done); end
    endtask

    task automatic test_signs();
        int lat, bc;
        run_op(-16'sd100, 16'sd7, lat, bc);
        total++; if (quotient !== 16'hFFF2) begin bad++; $display("FAIL nn_p_q got=%h want=fff2", quotient); end
        total++; if (remainder !== 16'hFFFE) begin bad++; $display("FAIL nn_p_r got=%h want=fffe", remainder); end
        run_op(16'sd100, -16'sd7, lat, bc);
        total++; if (quotient !== 16'hFFF2) begin bad++; $display("FAIL p_nd_q got=%h want=fff2", quotient); end
        total++; if (remainder !== 16'h0002) begin bad++; $display("FAIL p_nd_r got=%h want=0002", remainder); end
        run_op(-16'sd100, -16'sd7, lat, bc);
        total++; if (quotient !== 16'h000E) begin bad++; $display("FAIL n_nd_q got=%h want=000e", quotient); end
        total++; if (remainder !== 16'hFFFE) begin bad++; $display("FAIL n_nd_r got=%h want=fffe", remainder); end
        total++; if (lat != 17) begin bad++; $display("FAIL signs_latency got=%0d want=17", lat); end
    endtask

    task automatic test_overflow();
        int lat, bc;
        run_op(16'sh8000, -16'sd1, lat, bc);
        total++; if (quotient !== 16'h8000) begin bad++; $display("FAIL ovf_q got=%h want=8000", quotient); end
        total++; if (remainder !== 16'h0000) begin bad++; $display("FAIL ovf_r got=%h want=0000", remainder); end
        total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL ovf_dbz got=%b want=0", div_by_zero); end
    endtask

    task automatic test_div_zero();
        int lat, bc;
        run_op(16'sd1234, 16'sd0, lat, bc);
        total++; if (lat != ZLAT) begin bad++; $display("FAIL dz_latency got=%0d want=%0d", lat, ZLAT); end
        total++; if (bc != ZLAT) begin bad++; $display("FAIL dz_busy_cycles got=%0d want=%0d", bc, ZLAT); end
        total++; if (quotient !== 16'hFFFF) begin bad++; $display("FAIL dz_q got=%h want=ffff", quotient); end
        total++; if (remainder !== 16'd1234) begin bad++; $display("FAIL dz_r got=%h want=04d2", remainder); end
        total++; if (div_by_zero !== 1'b1) begin bad++; $display("FAIL dz_flag got=%b want=1", div_by_zero); end
        repeat (3) @(posedge clk);
        #1;
        total++; if (div_by_zero !== 1'b1) begin bad++; $display("FAIL dz_flag_hold got=%b want=1", div_by_zero); end
        total++; if (quotient !== 16'hFFFF) begin bad++; $display("FAIL dz_q_hold got=%h want=ffff", quotient); end
        run_op(16'sd9, 16'sd3, lat, bc);
        total++; if (quotient !== 16'd3) begin bad++; $display("FAIL after_dz_q got=%h want=0003", quotient); end
        total++; if (remainder !== 16'd0) begin bad++; $display("FAIL after_dz_r got=%h want=0000", remainder); end
        total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL after_dz_flag got=%b want=0", div_by_zero); end
    endtask

    task automatic test_start_while_busy();
        int dones, first, lat, bc;
        dones = 0;
        first = -1;
        @(negedge clk);
        dividend = 16'sd50;
        divisor  = 16'sd5;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            @(posedge clk);
            #1;
            if (i == 4) begin
                dividend = 16'sd77;
                divisor  = 16'sd7;
                start    = 1'b1;
            end
            if (i == 5) start = 1'b0;
            if (done) begin
                dones++;
                if (first < 0) first = i;
            end
        end
        total++; if (dones != 1) begin bad++; $display("FAIL busy_start_dones got=%0d want=1", dones); end
        total++; if (first != 17) begin bad++; $display("FAIL busy_start_latency got=%0d want=17", first); end
        total++; if (quotient !== 16'd10) begin bad++; $display("FAIL busy_start_q got=%h want=000a", quotient); end
        total++; if (remainder !== 16'd0) begin bad++; $display("FAIL busy_start_r got=%h want=0000", remainder); end
        // still in the done cycle: this start is sampled at the next edge
        run_op(16'sd77, 16'sd7, lat, bc);
        total++; if (lat != 17) begin bad++; $display("FAIL b2b_latency got=%0d want=17", lat); end
        total++; if (quotient !== 16'd11) begin bad++; $display("FAIL b2b_q got=%h want=000b", quotient); end
        total++; if (remainder !== 16'd0) begin bad++; $display("FAIL b2b_r got=%h want=0000", remainder); end
    endtask

    task automatic test_reset_mid();
        int dones, lat, bc;
        dones = 0;
        @(negedge clk);
        dividend = 16'sd1000;
        divisor  = 16'sd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        total++; if (quotient !== 16'h0000) begin bad++; $display("FAIL midrst_q got=%h want=0000", quotient); end
        total++; if (remainder !== 16'h0000) begin bad++; $display("FAIL midrst_r got=%h want=0000", remainder); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL midrst_done got=%b want=0", done); end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        total++; if (dones != 0) begin bad++; $display("FAIL midrst_spurious_done got=%0d want=0", dones); end
        run_op(16'sd1000, 16'sd3, lat, bc);
        total++; if (lat != 17) begin bad++; $display("FAIL midrst_new_latency got=%0d want=17", lat); end
        total++; if (quotient !== 16'd333) begin bad++; $display("FAIL midrst_new_q got=%h want=014d", quotient); end
        total++; if (remainder !== 16'd1) begin bad++; $display("FAIL midrst_new_r got=%h want=0001", remainder); end
    endtask

    initial begin
        test_reset();
        test_positive();
        test_signs();
        test_overflow();
        test_div_zero();
        test_start_while_busy();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
